// File: rtl/nkmd_dai_tx_sched.sv
// nkmd_dai_tx_sched
// Frame-driven scheduler that drains one sample per enabled channel from a
// bank of per-channel DAI tx ring buffers each audio frame. Channels are popped
// in ascending index order. Each sample is forwarded with its channel number
// over a valid/ready stream to a single shared serializer.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   frame_i      - one-cycle frame-start strobe
//   ch_en_i      - channel enable mask, sampled only when a frame is accepted
//   tx_pop_o     - one-hot pop to the channel buffers
//   tx_ack_i     - per-channel pop acknowledge (only the popped channel counts)
//   tx_data_i    - concatenated head samples, channel k at [24k+23:24k]
//   out_data_o   - sample to the serializer
//   out_ch_o     - channel index of out_data_o
//   out_valid_o  - stream valid, out_ready_i - stream ready
//   busy_o       - frame in progress
//   done_o       - one-cycle pulse when an accepted frame completes
//   overrun_o    - one-cycle pulse when a frame strobe is rejected
//   ack_err_o    - one-cycle pulse when a popped channel never acknowledged
// Every output comes straight from a flop.

module nkmd_dai_tx_sched #(
  parameter int NCH     = 4,
  parameter int CHW     = $clog2(NCH),
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_i,
  input  logic [NCH-1:0]    ch_en_i,
  output logic [NCH-1:0]    tx_pop_o,
  input  logic [NCH-1:0]    tx_ack_i,
  input  logic [NCH*24-1:0] tx_data_i,
  output logic [23:0]       out_data_o,
  output logic [CHW-1:0]    out_ch_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic              ack_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]     state_r,   state_s;
  logic [NCH-1:0] en_r,      en_s;
  logic [CHW-1:0] ch_r,      ch_s;
  logic [23:0]    data_r,    data_s;
  logic [7:0]     tmo_r,     tmo_s;
  logic [NCH-1:0] pop_r,     pop_s;
  logic           valid_r,   valid_s;
  logic           busy_r,    busy_s;
  logic           done_r,    done_s;
  logic           overrun_r, overrun_s;
  logic           ack_err_r, ack_err_s;
  logic [NCH-1:0] above_s;
  logic           adv_s;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [CHW-1:0] lowest_idx(input logic [NCH-1:0] v);
    logic [CHW-1:0] idx;
    logic           found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] && !found) begin
        idx   = CHW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] ch);
    logic [NCH-1:0] r;
    r     = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  // Channels of the current frame that still remain above the active one.
  always_comb begin
    above_s = '0;
    for (int i = 0; i < NCH; i++) begin
      above_s[i] = en_r[i] & (CHW'(i) > ch_r);
    end
  end

  // Next state and next register values; outputs are precomputed here so
  // they can be registered.
  always_comb begin
    state_s   = state_r;
    en_s      = en_r;
    ch_s      = ch_r;
    data_s    = data_r;
    tmo_s     = tmo_r;
    done_s    = 1'b0;
    ack_err_s = 1'b0;
    adv_s     = 1'b0;
    // Any strobe outside IDLE is dropped, including the last handshake cycle.
    overrun_s = frame_i & (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (frame_i) begin
          if (|ch_en_i) begin
            en_s    = ch_en_i;
            ch_s    = lowest_idx(ch_en_i);
            state_s = ST_POP;
          end else begin
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_POP: begin
        // The buffer head advances on this edge, so capture it now.
        data_s  = tx_data_i[int'(ch_r)*24 +: 24];
        tmo_s   = 8'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ack_i[ch_r]) begin
          state_s = ST_OUT;
        end else if (tmo_r == 8'(TIMEOUT - 1)) begin
          ack_err_s = 1'b1;
          adv_s     = 1'b1;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          adv_s = 1'b1;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Advance to the next enabled channel or finish the frame.
    if (adv_s) begin
      if (|above_s) begin
        ch_s    = lowest_idx(above_s);
        state_s = ST_POP;
      end else begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end
    end else begin
      ch_s = ch_s;
    end
    pop_s   = (state_s == ST_POP) ? onehot(ch_s) : '0;
    valid_s = (state_s == ST_OUT);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      en_r      <= '0;
      ch_r      <= '0;
      data_r    <= 24'd0;
      tmo_r     <= 8'd0;
      pop_r     <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      ack_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      en_r      <= en_s;
      ch_r      <= ch_s;
      data_r    <= data_s;
      tmo_r     <= tmo_s;
      pop_r     <= pop_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      overrun_r <= overrun_s;
      ack_err_r <= ack_err_s;
    end
  end

  assign tx_pop_o    = pop_r;
  assign out_data_o  = data_r;
  assign out_ch_o    = ch_r;
  assign out_valid_o = valid_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign overrun_o   = overrun_r;
  assign ack_err_o   = ack_err_r;

endmodule

// File: doc/nkmd_dai_tx_sched.md
# nkmd_dai_tx_sched

Frame-driven scheduler that drains one sample per enabled channel from a bank of per-channel DAI tx ring buffers each audio frame. It sits between the per-channel DAI tx buffers (pop/ack/data interface) and a single shared downstream serializer. On each `frame_i` strobe it pops the channels in ascending index order and forwards each sample, tagged with its channel number, over a valid/ready stream. It flags frame overruns and missing acknowledgements.

## Interface
Parameters:
- `NCH`, 4: number of tx channels, 2..16.
- `CHW`, `$clog2(NCH)`: channel index width.
- `TIMEOUT`, 8: WAIT cycles allowed for an ack, 1..255.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_i`  in  1  one-cycle frame-start strobe.
- `ch_en_i`  in  NCH  channel enable mask; sampled only on frame accept.
- `tx_pop_o`  out  NCH  one-hot pop to the channel buffers; at most one bit high.
- `tx_ack_i`  in  NCH  per-channel pop acknowledge, nominally one cycle after pop.
- `tx_data_i`  in  NCH*24  concatenated channel head samples; channel k at bits [24k+23:24k].
- `out_data_o`  out  24  sample to the serializer.
- `out_ch_o`  out  CHW  channel index of `out_data_o`.
- `out_valid_o`  out  1  stream valid.
- `out_ready_i`  in  1  stream ready.
- `busy_o`  out  1  high whenever the FSM is not IDLE.
- `done_o`  out  1  one-cycle pulse when an accepted frame completes.
- `overrun_o`  out  1  one-cycle pulse when a frame is rejected.
- `ack_err_o`  out  1  one-cycle pulse on ack timeout.

## Operation
- FSM states: IDLE, POP, WAIT, OUT. Registers: `en_ff[NCH]`, `ch_ff[CHW]`, `data_ff[24]`, `tmo_ff[8]`.
- IDLE, `frame_i`=1, `ch_en_i`≠0: set `en_ff`=`ch_en_i` and `ch_ff`=lowest set index, then go to POP.
- IDLE, `frame_i`=1, `ch_en_i`=0: pulse `done_o` next cycle and stay in IDLE.
- POP (exactly 1 cycle): `tx_pop_o[ch_ff]`=1. Latch `data_ff` from slice `ch_ff` of `tx_data_i` in this cycle, because the buffer's head advances on the pop edge. Clear `tmo_ff`, then go to WAIT.
- WAIT, `tx_ack_i[ch_ff]`=1: go to OUT. Ack bits of other channels are ignored in every state.
- WAIT, no ack: increment `tmo_ff`. When `tmo_ff`==TIMEOUT-1 with no ack, pulse `ack_err_o`, drop the sample (no OUT) and advance.
- OUT: `out_valid_o`=1, `out_data_o`=`data_ff`, `out_ch_o`=`ch_ff`. These are held stable until `out_ready_i`=1; the handshake cycle then advances.
- Advance is combinational, with no extra state:
  - If `en_ff` has a set bit above `ch_ff`, load the next such index and go to POP.
  - Otherwise go to IDLE and pulse `done_o` in the first IDLE cycle.
- A frame is accepted only when the state is IDLE at that edge.
  - `frame_i` in any other state, including the final OUT handshake cycle, pulses `overrun_o` the next cycle.
  - The rejected frame is dropped, not queued.
- Changes to `ch_en_i` mid-frame have no effect until the next accepted frame.
- Reset, including mid-frame, aborts the current frame without asserting `done_o`.
- Reset values: state IDLE; all of `tx_pop_o`, `out_*`, `busy_o`, `done_o`, `overrun_o`, `ack_err_o`, `en_ff`, `ch_ff`, `data_ff`, `tmo_ff` = 0.

## Timing
- `frame_i` accepted at cycle t gives: pop at t+1, ack expected at t+2, `out_valid_o` at t+3.
- With `out_ready_i` held high, each channel takes 3 cycles and the next pop is at t+4.
- All 4 channels enabled, ready always high: pops at t+1, t+4, t+7, t+10; last handshake at t+12; `done_o`=1 and `busy_o`=0 at t+13.
- A timed-out channel occupies 1+TIMEOUT cycles (POP plus WAIT). The next channel's POP follows immediately.
- Every output is driven from a register; no combinational path from an input to any output.
- `tx_pop_o` is never high for two consecutive cycles on the same channel.

## Test plan
- Reset, then `ch_en_i`=4'b1111, ack one cycle after each pop, ready high, head samples 0x000011/0x000022/0x000033/0x000044:
  - Required: stream (ch0,0x000011), (ch1,0x000022), (ch2,0x000033), (ch3,0x000044).
  - Required: `done_o` at t+13.
- Sparse mask `ch_en_i`=4'b1010: only ch1 then ch3 are popped; `done_o` at t+7. Then `ch_en_i`=0 with `frame_i`: `done_o` at t+1 and no pop.
- Ready backpressure: `out_ready_i` low for 5 cycles in the first OUT.
  - Required: valid, data and channel held constant; no further pop until the handshake; the frame still completes.
- Ack timeout, TIMEOUT=8, ch2 never acks:
  - Required: `ack_err_o` pulses once; no output for ch2; ch3 popped on the cycle after the error; `done_o` still fires.
- Overrun: `frame_i` at t+5 and again in the final handshake cycle.
  - Required: two `overrun_o` pulses; stream unaffected.
  - Required: a `frame_i` at t+13 (IDLE) is accepted.
- Async reset asserted mid-WAIT:
  - Required: all outputs go to 0 immediately with no `done_o`.
  - Required: after release, the next frame runs from ch0.
